// File: rtl/vm_multi_ctrl_pkg.sv
// Shared definitions for the multi-product vending controller: FSM state
// encodings and coin values, common with the legacy coffee block.
package vm_multi_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READY    = 3'd1,
        S_DISPENSE = 3'd2,
        S_CHANGE   = 3'd3,
        S_FAULT    = 3'd4
    } state_t;

    localparam int unsigned COIN5  = 5;
    localparam int unsigned COIN10 = 10;

endpackage

// File: rtl/vm_credit.sv
// Credit accumulator: coin add with ceiling/reject, price subtract/restore,
// change decrement. Credit and coin_rej are registered.
module vm_credit
    import vm_multi_ctrl_pkg::*;
#(
    parameter int PRICE      = 15,
    parameter int CREDIT_MAX = 50,
    parameter int CREDIT_W   = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_en,
    input  logic                c5,
    input  logic                c10,
    input  logic                sub_price,
    input  logic                restore,
    input  logic                dec5,
    output logic [CREDIT_W-1:0] credit,
    output logic [CREDIT_W-1:0] credit_coin,
    output logic                coin_rej
);

    localparam int SUM_W = CREDIT_W + 1;

    logic [SUM_W-1:0]    coin_val;
    logic [SUM_W-1:0]    sum;
    logic [SUM_W-1:0]    restored;
    logic                accept;
    logic                reject;
    logic [CREDIT_W-1:0] credit_n;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        coin_val = '0;
        if (c5)
            coin_val = coin_val + SUM_W'(COIN5);
        if (c10)
            coin_val = coin_val + SUM_W'(COIN10);

        // One extra bit so an over-ceiling sum is seen rather than wrapped.
        sum         = {1'b0, credit} + coin_val;
        accept      = coin_en && (c5 || c10) && (sum <= SUM_W'(CREDIT_MAX));
        reject      = (c5 || c10) && !accept;
        credit_coin = accept ? sum[CREDIT_W-1:0] : credit;

        restored = {1'b0, credit} + SUM_W'(PRICE);
        if (restored > SUM_W'(CREDIT_MAX))
            restored = SUM_W'(CREDIT_MAX);

        credit_n = credit_coin;
        if (dec5)
            credit_n = credit - CREDIT_W'(COIN5);
        else if (restore)
            credit_n = restored[CREDIT_W-1:0];
        else if (sub_price)
            credit_n = credit_coin - CREDIT_W'(PRICE);
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            credit   <= '0;
            coin_rej <= 1'b0;
        end else begin
            credit   <= credit_n;
            coin_rej <= reject;
        end
    end

endmodule

// File: rtl/vm_multi_ctrl.sv
// Multi-product vending controller: FSM, dispense timer and registered
// outputs decoded from next-state logic; credit lives in vm_credit.
module vm_multi_ctrl
    import vm_multi_ctrl_pkg::*;
#(
    parameter int N_PROD     = 4,
    parameter int PRICE      = 15,
    parameter int CREDIT_MAX = 50,
    parameter int CREDIT_W   = 6,
    parameter int WATER_W    = 5,
    parameter int WATER_MIN  = 2,
    parameter int DISP_CYC   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                c10,
    input  logic                c5,
    input  logic                nfc,
    input  logic                cancel,
    input  logic [N_PROD-1:0]   sel,
    input  logic [N_PROD-1:0]   stock,
    input  logic [WATER_W-1:0]  water,
    output logic [N_PROD-1:0]   dispense,
    output logic                change_5,
    output logic                coin_rej,
    output logic                error,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    localparam int CNT_W = (DISP_CYC > 1) ? $clog2(DISP_CYC) : 1;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [N_PROD-1:0]   prod, prod_n;
    logic                coin_paid, coin_paid_n;
    logic                coin_en, sub_price, restore, dec5, err_evt;
    logic                water_ok, ok, sel_onehot, sel_valid;
    logic [CREDIT_W-1:0] credit_coin;

    assign water_ok   = water >= WATER_W'(WATER_MIN);
    assign ok         = water_ok && (|stock);
    assign sel_onehot = (|sel) && ((sel & (sel - N_PROD'(1))) == '0);
    assign sel_valid  = sel_onehot && (|(sel & stock));

    vm_credit #(
        .PRICE      (PRICE),
        .CREDIT_MAX (CREDIT_MAX),
        .CREDIT_W   (CREDIT_W)
    ) u_credit (
        .clk         (clk),
        .rst         (rst),
        .coin_en     (coin_en),
        .c5          (c5),
        .c10         (c10),
        .sub_price   (sub_price),
        .restore     (restore),
        .dec5        (dec5),
        .credit      (credit),
        .credit_coin (credit_coin),
        .coin_rej    (coin_rej)
    );

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        prod_n      = prod;
        coin_paid_n = coin_paid;
        coin_en     = 1'b0;
        sub_price   = 1'b0;
        restore     = 1'b0;
        dec5        = 1'b0;
        err_evt     = 1'b0;

        case (state)
            S_IDLE: begin
                if (ok)
                    state_n = S_READY;
            end
            S_READY: begin
                coin_en = 1'b1;
                // Decisions use post-coin credit: this cycle's coins land first.
                if (!ok) begin
                    state_n = (credit_coin != '0) ? S_CHANGE : S_IDLE;
                end else if (cancel) begin
                    if (credit_coin != '0)
                        state_n = S_CHANGE;
                end else if (|sel) begin
                    if (sel_valid && !nfc) begin
                        state_n     = S_DISPENSE;
                        prod_n      = sel;
                        cnt_n       = '0;
                        coin_paid_n = 1'b0;
                    end else if (sel_valid && credit_coin >= CREDIT_W'(PRICE)) begin
                        state_n     = S_DISPENSE;
                        prod_n      = sel;
                        cnt_n       = '0;
                        coin_paid_n = 1'b1;
                        sub_price   = 1'b1;
                    end else begin
                        err_evt = 1'b1;
                    end
                end
            end
            S_DISPENSE: begin
                if (!water_ok) begin
                    state_n = S_FAULT;
                    restore = coin_paid;
                end else if (cnt == CNT_W'(DISP_CYC - 1)) begin
                    state_n = S_READY;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_CHANGE: begin
                dec5 = (credit != '0);
                if (credit <= CREDIT_W'(COIN5))
                    state_n = S_IDLE;
            end
            S_FAULT: begin
                if (water_ok)
                    state_n = (credit != '0) ? S_CHANGE : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            prod      <= '0;
            coin_paid <= 1'b0;
            dispense  <= '0;
            change_5  <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            prod      <= prod_n;
            coin_paid <= coin_paid_n;
            dispense  <= (state_n == S_DISPENSE) ? prod_n : '0;
            change_5  <= dec5;
            error     <= err_evt || (state_n == S_FAULT);
            busy      <= (state_n == S_DISPENSE) || (state_n == S_CHANGE) ||
                         (state_n == S_FAULT);
        end
    end

endmodule

// File: tb/tb_vm_multi_ctrl.sv
// Directed self-checking bench for vm_multi_ctrl with default parameters.
module tb_vm_multi_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       c10, c5, nfc, cancel;
    logic [3:0] sel, stock;
    logic [4:0] water;
    logic [3:0] dispense;
    logic       change_5, coin_rej, error, busy;
    logic [5:0] credit;

    int checks = 0;
    int errors = 0;
    int hits;

    always #5 clk = ~clk;

    vm_multi_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .c10      (c10),
        .c5       (c5),
        .nfc      (nfc),
        .cancel   (cancel),
        .sel      (sel),
        .stock    (stock),
        .water    (water),
        .dispense (dispense),
        .change_5 (change_5),
        .coin_rej (coin_rej),
        .error    (error),
        .busy     (busy),
        .credit   (credit)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic v5, input logic v10);
        c5  = v5;
        c10 = v10;
        tick();
        c5  = 1'b0;
        c10 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; c10 = 1'b0; c5 = 1'b0; nfc = 1'b1; cancel = 1'b0;
        sel = 4'b0000; stock = 4'b1111; water = 5'd10;
        tick();
        tick();
        check("reset_dispense", 32'(dispense), 32'd0);
        check("reset_credit",   32'(credit),   32'd0);
        check("reset_busy",     32'(busy),     32'd0);
        check("reset_error",    32'(error),    32'd0);
        check("reset_change5",  32'(change_5), 32'd0);
        check("reset_coinrej",  32'(coin_rej), 32'd0);
        rst = 1'b1;
        tick();

        // Coins then a paid select; dispense lasts exactly 8 cycles.
        coin(1'b0, 1'b1);
        check("t1_credit10", 32'(credit), 32'd10);
        coin(1'b1, 1'b0);
        check("t1_credit15", 32'(credit), 32'd15);
        sel = 4'b0010;
        tick();
        sel = 4'b0000;
        check("t1_dispense_on", 32'(dispense), 32'b0010);
        check("t1_credit0",     32'(credit),   32'd0);
        check("t1_busy",        32'(busy),     32'd1);
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            if (dispense == 4'b0010) hits++;
            tick();
        end
        check("t1_disp_cycles", 32'(hits), 32'd8);
        check("t1_disp_off",    32'(dispense), 32'd0);
        check("t1_idle_busy",   32'(busy), 32'd0);

        // Ceiling reject at 45, then cancel returns nine 5-unit coins.
        for (int i = 0; i < 4; i++) coin(1'b0, 1'b1);
        coin(1'b1, 1'b0);
        check("t2_credit45", 32'(credit), 32'd45);
        coin(1'b0, 1'b1);
        check("t2_coinrej",      32'(coin_rej), 32'd1);
        check("t2_credit_stays", 32'(credit),   32'd45);
        tick();
        check("t2_coinrej_pulse", 32'(coin_rej), 32'd0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("t2_change_busy", 32'(busy), 32'd1);
        hits = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (change_5) hits++;
        end
        check("t2_change_count", 32'(hits),   32'd9);
        check("t2_credit0",      32'(credit), 32'd0);

        // Invalid selects: unpaid, non-one-hot, out of stock.
        coin(1'b0, 1'b1);
        sel = 4'b0001;
        tick();
        sel = 4'b0000;
        check("t4_unpaid_error",    32'(error),    32'd1);
        check("t4_unpaid_nodisp",   32'(dispense), 32'd0);
        check("t4_unpaid_credit",   32'(credit),   32'd10);
        tick();
        check("t4_error_pulse",     32'(error),    32'd0);
        sel = 4'b0011;
        tick();
        sel = 4'b0000;
        check("t4_multi_error",     32'(error),    32'd1);
        check("t4_multi_nodisp",    32'(dispense), 32'd0);
        tick();
        stock = 4'b0111;
        sel = 4'b1000;
        tick();
        sel = 4'b0000;
        check("t4_nostock_error",   32'(error),    32'd1);
        check("t4_nostock_nodisp",  32'(dispense), 32'd0);
        stock = 4'b1111;
        tick();

        // Card payment with credit 20: credit untouched.
        coin(1'b0, 1'b1);
        check("t3_credit20", 32'(credit), 32'd20);
        nfc = 1'b0;
        sel = 4'b0100;
        tick();
        nfc = 1'b1;
        sel = 4'b0000;
        check("t3_dispense_on", 32'(dispense), 32'b0100);
        check("t3_credit_kept", 32'(credit),   32'd20);
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            if (dispense == 4'b0100) hits++;
            tick();
        end
        check("t3_disp_cycles", 32'(hits),   32'd8);
        check("t3_credit_end",  32'(credit), 32'd20);

        // Drain, then water loss mid-dispense restores the price.
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        coin(1'b1, 1'b1);
        check("t5_both_coins", 32'(credit), 32'd15);
        sel = 4'b0010;
        tick();
        sel = 4'b0000;
        check("t5_credit_deduct", 32'(credit), 32'd0);
        tick();
        tick();
        check("t5_disp_cycle3", 32'(dispense), 32'b0010);
        water = 5'd1;
        tick();
        check("t5_abort_disp",   32'(dispense), 32'd0);
        check("t5_fault_error",  32'(error),    32'd1);
        check("t5_fault_busy",   32'(busy),     32'd1);
        check("t5_restored",     32'(credit),   32'd15);
        tick();
        check("t5_error_held",   32'(error),    32'd1);
        water = 5'd2;
        tick();
        check("t5_error_clear",  32'(error),    32'd0);
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            if (change_5) hits++;
            tick();
        end
        check("t5_change_count", 32'(hits),   32'd3);
        check("t5_credit0",      32'(credit), 32'd0);

        // Reset during dispense cycle 4: outputs clear without a clock edge.
        coin(1'b0, 1'b1);
        coin(1'b0, 1'b1);
        coin(1'b1, 1'b0);
        sel = 4'b0001;
        tick();
        sel = 4'b0000;
        check("t6_credit10", 32'(credit), 32'd10);
        tick();
        tick();
        tick();
        check("t6_disp_cycle4", 32'(dispense), 32'b0001);
        rst = 1'b0;
        #1;
        check("t6_rst_dispense", 32'(dispense), 32'd0);
        check("t6_rst_busy",     32'(busy),     32'd0);
        check("t6_rst_credit",   32'(credit),   32'd0);
        tick();
        rst = 1'b1;
        tick();
        coin(1'b1, 1'b0);
        check("t6_ready_credit",  32'(credit),   32'd5);
        check("t6_ready_coinrej", 32'(coin_rej), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
